// File: rtl/sdp_banked_ram_if.sv
// Bus bundle for sdp_banked_ram: write port, broadcast read port with tag,
// clear-engine control and status.
interface sdp_banked_ram_if #(
  parameter int NUM_BANK  = 4,
  parameter int NB_COL    = 8,
  parameter int COL_WIDTH = 8,
  parameter int RAM_DEPTH = 512,
  parameter int TAG_WIDTH = 4
);
  // Bank/address fields are wide enough to carry NUM_BANK / RAM_DEPTH themselves,
  // so an out-of-range bank number is representable and can be flagged.
  localparam int BW = $clog2(NUM_BANK + 1);
  localparam int AW = $clog2(RAM_DEPTH + 1);
  localparam int DW = NB_COL * COL_WIDTH;

  logic                       wr_en;
  logic [BW-1:0]              wr_bank;
  logic [AW-1:0]              wr_addr;
  logic [NB_COL-1:0]          wr_be;
  logic [DW-1:0]              wr_data;
  logic                       rd_en;
  logic [AW-1:0]              rd_addr;
  logic [TAG_WIDTH-1:0]       rd_tag_in;
  logic                       rd_valid;
  logic [TAG_WIDTH-1:0]       rd_tag;
  logic [NUM_BANK*DW-1:0]     rd_data;
  logic                       clr_start;
  logic                       clr_busy;
  logic                       clr_done;
  logic                       wr_err;

  modport master (
    output wr_en, wr_bank, wr_addr, wr_be, wr_data,
    output rd_en, rd_addr, rd_tag_in, clr_start,
    input  rd_valid, rd_tag, rd_data, clr_busy, clr_done, wr_err
  );

  modport slave (
    input  wr_en, wr_bank, wr_addr, wr_be, wr_data,
    input  rd_en, rd_addr, rd_tag_in, clr_start,
    output rd_valid, rd_tag, rd_data, clr_busy, clr_done, wr_err
  );
endinterface

// File: rtl/sdp_banked_ram.sv
// Multi-bank simple-dual-port RAM: single-bank byte-masked write, all-bank
// parallel read with tagged 1/2-cycle latency, and a sequential zero-clear engine.
module sdp_banked_ram #(
  parameter int    NUM_BANK   = 4,
  parameter int    NB_COL     = 8,
  parameter int    COL_WIDTH  = 8,
  parameter int    RAM_DEPTH  = 512,
  parameter int    RD_LATENCY = 2,
  parameter string WRITE_MODE = "READ_FIRST",
  parameter int    TAG_WIDTH  = 4,
  parameter string RAM_TYPE   = "block"
) (
  input logic            clk,
  input logic            rst_n,
  sdp_banked_ram_if.slave bus
);

  localparam int BW = $clog2(NUM_BANK + 1);
  localparam int AW = $clog2(RAM_DEPTH + 1);
  localparam int IW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int DW = NB_COL * COL_WIDTH;
  localparam bit WF = (WRITE_MODE == "WRITE_FIRST");

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  typedef logic [NB_COL-1:0][COL_WIDTH-1:0] word_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q;
  logic            clr_we;
  logic            clr_last;
  logic            idle;
  logic            rd_acc;
  logic            wr_acc;
  logic            wr_bad;
  word_t           wr_lanes;
  logic            v1_q;
  logic [TAG_WIDTH-1:0] tag1_q;
  word_t           rd_word_q [NUM_BANK];
  logic [NUM_BANK*DW-1:0] rd_flat;

  // Request qualification: user traffic is only accepted while the clear engine is idle
  always_comb begin
    idle     = (state_q == ST_IDLE);
    rd_acc   = bus.rd_en && idle;
    wr_bad   = (bus.wr_bank >= BW'(NUM_BANK));
    wr_acc   = bus.wr_en && idle && !wr_bad;
    wr_lanes = bus.wr_data;
  end

  // Clear FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Clear FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.clr_start) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_last)      state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Clear FSM outputs
  always_comb begin
    clr_we       = (state_q == ST_CLEAR);
    clr_last     = clr_we && (clr_cnt_q == AW'(RAM_DEPTH - 1));
    bus.clr_busy = clr_we;
  end

  // Clear address counter and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q    <= '0;
      bus.clr_done <= 1'b0;
    end else begin
      bus.clr_done <= clr_last;
      if (clr_we) clr_cnt_q <= clr_cnt_q + 1'b1;
      else        clr_cnt_q <= '0;
    end
  end

  // Out-of-range bank write flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.wr_err <= 1'b0;
    else        bus.wr_err <= bus.wr_en && idle && wr_bad;
  end

  // First read stage: valid and tag travel alongside the array read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      tag1_q <= '0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) tag1_q <= bus.rd_tag_in;
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    (* ram_style = RAM_TYPE *) word_t mem [RAM_DEPTH];

    logic          bank_we;
    logic [IW-1:0] bank_addr;
    logic [NB_COL-1:0] bank_be;
    word_t         bank_din;
    logic          hit;

    // Write-port mux: the clear engine owns every bank while active
    always_comb begin
      if (clr_we) begin
        bank_we   = 1'b1;
        bank_addr = clr_cnt_q[IW-1:0];
        bank_be   = '1;
        bank_din  = '0;
      end else begin
        bank_we   = wr_acc && (bus.wr_bank == BW'(b));
        bank_addr = bus.wr_addr[IW-1:0];
        bank_be   = bus.wr_be;
        bank_din  = wr_lanes;
      end
      hit = WF && wr_acc && (bus.wr_bank == BW'(b)) && (bus.wr_addr == bus.rd_addr);
    end

    // Byte-masked array write
    always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NB_COL; i++) begin
        if (bank_we && bank_be[i]) mem[bank_addr][i] <= bank_din[i];
      end
    end

    // Array read; a same-address write bypasses per lane only in write-first mode
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_word_q[b] <= '0;
      end else if (rd_acc) begin
        for (int unsigned i = 0; i < NB_COL; i++) begin
          rd_word_q[b][i] <= (hit && bus.wr_be[i]) ? wr_lanes[i] : mem[bus.rd_addr[IW-1:0]][i];
        end
      end
    end
  end

  // Pack bank words into the flat read bus, bank 0 in the low slice
  always_comb begin
    rd_flat = '0;
    for (int unsigned b = 0; b < NUM_BANK; b++) rd_flat[b*DW +: DW] = rd_word_q[b];
  end

  if (RD_LATENCY == 1) begin : g_lat1
    // Single-cycle latency: the array read register is the output
    always_comb begin
      bus.rd_valid = v1_q;
      bus.rd_tag   = tag1_q;
      bus.rd_data  = rd_flat;
    end
  end else begin : g_lat2
    // Extra output register; data and tag only advance with a valid read
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bus.rd_valid <= 1'b0;
        bus.rd_tag   <= '0;
        bus.rd_data  <= '0;
      end else begin
        bus.rd_valid <= v1_q;
        if (v1_q) begin
          bus.rd_tag  <= tag1_q;
          bus.rd_data <= rd_flat;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdp_banked_ram.sv
// Directed bench: dut0 = latency 2 / READ_FIRST, dut1 = latency 1 / WRITE_FIRST,
// both driven with identical stimulus.
module tb_sdp_banked_ram;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sdp_banked_ram_if #(.NUM_BANK(4), .NB_COL(8), .COL_WIDTH(8), .RAM_DEPTH(512), .TAG_WIDTH(4)) bus0 ();
  sdp_banked_ram_if #(.NUM_BANK(4), .NB_COL(8), .COL_WIDTH(8), .RAM_DEPTH(512), .TAG_WIDTH(4)) bus1 ();

  assign bus1.wr_en     = bus0.wr_en;
  assign bus1.wr_bank   = bus0.wr_bank;
  assign bus1.wr_addr   = bus0.wr_addr;
  assign bus1.wr_be     = bus0.wr_be;
  assign bus1.wr_data   = bus0.wr_data;
  assign bus1.rd_en     = bus0.rd_en;
  assign bus1.rd_addr   = bus0.rd_addr;
  assign bus1.rd_tag_in = bus0.rd_tag_in;
  assign bus1.clr_start = bus0.clr_start;

  sdp_banked_ram #(
    .NUM_BANK(4), .NB_COL(8), .COL_WIDTH(8), .RAM_DEPTH(512), .RD_LATENCY(2),
    .WRITE_MODE("READ_FIRST"), .TAG_WIDTH(4), .RAM_TYPE("block")
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  sdp_banked_ram #(
    .NUM_BANK(4), .NB_COL(8), .COL_WIDTH(8), .RAM_DEPTH(512), .RD_LATENCY(1),
    .WRITE_MODE("WRITE_FIRST"), .TAG_WIDTH(4), .RAM_TYPE("block")
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.wr_en     = 1'b0;
    bus0.wr_bank   = '0;
    bus0.wr_addr   = '0;
    bus0.wr_be     = '0;
    bus0.wr_data   = '0;
    bus0.rd_en     = 1'b0;
    bus0.rd_addr   = '0;
    bus0.rd_tag_in = '0;
    bus0.clr_start = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] bank, input logic [9:0] addr,
                          input logic [7:0] be, input logic [63:0] data);
    bus0.wr_en = 1'b1; bus0.wr_bank = bank; bus0.wr_addr = addr;
    bus0.wr_be = be;   bus0.wr_data = data;
    tick();
    bus0.wr_en = 1'b0;
  endtask

  // Issues one read (alongside any write already set up) and captures both DUTs
  task automatic issue_read(input logic [9:0] addr, input logic [3:0] tag,
                            output logic v1, output logic [3:0] t1, output logic [255:0] d1,
                            output logic v0_early, output logic v0, output logic [3:0] t0,
                            output logic [255:0] d0);
    bus0.rd_en = 1'b1; bus0.rd_addr = addr; bus0.rd_tag_in = tag;
    tick();
    bus0.rd_en = 1'b0; bus0.wr_en = 1'b0;
    v1 = bus1.rd_valid; t1 = bus1.rd_tag; d1 = bus1.rd_data;
    v0_early = bus0.rd_valid;
    tick();
    v0 = bus0.rd_valid; t0 = bus0.rd_tag; d0 = bus0.rd_data;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (bus0.rd_valid !== 1'b0 || bus0.rd_tag !== 4'h0 || bus0.rd_data !== 256'h0) begin
      failures++;
      $display("FAIL reset_rd: valid=%b tag=%h data=%h expected 0/0/0", bus0.rd_valid, bus0.rd_tag, bus0.rd_data);
    end
    checks++;
    if (bus0.clr_busy !== 1'b0 || bus0.clr_done !== 1'b0 || bus0.wr_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: busy=%b done=%b err=%b expected 0/0/0", bus0.clr_busy, bus0.clr_done, bus0.wr_err);
    end
    checks++;
    if (bus1.rd_valid !== 1'b0 || bus1.rd_data !== 256'h0 || bus1.clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut1: valid=%b data=%h busy=%b expected 0/0/0", bus1.rd_valid, bus1.rd_data, bus1.clr_busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    int n = 0;
    int spurious = 0;
    logic v1, v0e, v0;
    logic [3:0] t1, t0;
    logic [255:0] d1, d0;
    logic [9:0] addrs [3] = '{10'd0, 10'd255, 10'd511};
    bus0.clr_start = 1'b1;
    tick();
    // traffic during the clear must be ignored, including a write to address 0
    while (bus0.clr_busy === 1'b1 && n < 600) begin
      n++;
      bus0.rd_en = 1'b1; bus0.rd_addr = 10'd0;
      bus0.wr_en = 1'b1; bus0.wr_bank = 3'd0; bus0.wr_addr = 10'd0;
      bus0.wr_be = 8'hFF; bus0.wr_data = '1;
      bus0.clr_start = 1'b1;
      tick();
      if (bus0.rd_valid || bus1.rd_valid || bus0.wr_err) spurious++;
    end
    idle_inputs();
    checks++;
    if (n != 512) begin
      failures++;
      $display("FAIL clear_len: busy cycles=%0d expected 512", n);
    end
    checks++;
    if (bus0.clr_done !== 1'b1 || bus1.clr_done !== 1'b1) begin
      failures++;
      $display("FAIL clear_done: dut0=%b dut1=%b expected 1/1", bus0.clr_done, bus1.clr_done);
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL clear_ignore: spurious valid/err cycles=%0d expected 0", spurious);
    end
    tick();
    checks++;
    if (bus0.clr_done !== 1'b0 || bus0.clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_pulse: done=%b busy=%b expected 0/0", bus0.clr_done, bus0.clr_busy);
    end
    foreach (addrs[k]) begin
      issue_read(addrs[k], 4'(k), v1, t1, d1, v0e, v0, t0, d0);
      checks++;
      if (v0 !== 1'b1 || d0 !== 256'h0 || v1 !== 1'b1 || d1 !== 256'h0) begin
        failures++;
        $display("FAIL clear_read addr=%0d: v0=%b d0=%h v1=%b d1=%h expected valid and zero",
                 addrs[k], v0, d0, v1, d1);
      end
    end
  endtask

  task automatic test_byte_write();
    logic v1, v0e, v0;
    logic [3:0] t1, t0;
    logic [255:0] d1, d0, expv;
    expv = '0;
    expv[128 +: 64] = 64'h0000_0000_5566_7788;
    do_write(3'd2, 10'd5, 8'h0F, 64'h1122_3344_5566_7788);
    issue_read(10'd5, 4'h3, v1, t1, d1, v0e, v0, t0, d0);
    checks++;
    if (v0e !== 1'b0) begin
      failures++;
      $display("FAIL byte_lat2_early: valid at t+1=%b expected 0", v0e);
    end
    checks++;
    if (v0 !== 1'b1 || t0 !== 4'h3 || d0 !== expv) begin
      failures++;
      $display("FAIL byte_dut0: valid=%b tag=%h data=%h expected 1/3/%h", v0, t0, d0, expv);
    end
    checks++;
    if (v1 !== 1'b1 || t1 !== 4'h3 || d1 !== expv) begin
      failures++;
      $display("FAIL byte_dut1: valid=%b tag=%h data=%h expected 1/3/%h", v1, t1, d1, expv);
    end
    tick();
    checks++;
    if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== expv || bus0.rd_tag !== 4'h3) begin
      failures++;
      $display("FAIL byte_hold: valid=%b tag=%h data=%h expected 0/3/%h", bus0.rd_valid, bus0.rd_tag, bus0.rd_data, expv);
    end
  endtask

  task automatic test_collision();
    logic v1, v0e, v0;
    logic [3:0] t1, t0;
    logic [255:0] d1, d0, exp_rf, exp_wf;
    do_write(3'd1, 10'd7, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA);
    // full-word overwrite in the same cycle as the read
    bus0.wr_en = 1'b1; bus0.wr_bank = 3'd1; bus0.wr_addr = 10'd7;
    bus0.wr_be = 8'hFF; bus0.wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    issue_read(10'd7, 4'h5, v1, t1, d1, v0e, v0, t0, d0);
    exp_rf = '0; exp_rf[64 +: 64] = 64'hAAAA_AAAA_AAAA_AAAA;
    exp_wf = '0; exp_wf[64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    checks++;
    if (v0 !== 1'b1 || t0 !== 4'h5 || d0 !== exp_rf) begin
      failures++;
      $display("FAIL coll_read_first: valid=%b tag=%h data=%h expected 1/5/%h", v0, t0, d0, exp_rf);
    end
    checks++;
    if (v1 !== 1'b1 || t1 !== 4'h5 || d1 !== exp_wf) begin
      failures++;
      $display("FAIL coll_write_first: valid=%b tag=%h data=%h expected 1/5/%h", v1, t1, d1, exp_wf);
    end
    // partial-lane overwrite: write-first merges per lane
    bus0.wr_en = 1'b1; bus0.wr_bank = 3'd1; bus0.wr_addr = 10'd7;
    bus0.wr_be = 8'h0F; bus0.wr_data = 64'h0;
    issue_read(10'd7, 4'h6, v1, t1, d1, v0e, v0, t0, d0);
    exp_wf = '0; exp_wf[64 +: 64] = 64'hFFFF_FFFF_0000_0000;
    exp_rf = '0; exp_rf[64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    checks++;
    if (d0 !== exp_rf || d1 !== exp_wf) begin
      failures++;
      $display("FAIL coll_merge: d0=%h d1=%h expected %h / %h", d0, d1, exp_rf, exp_wf);
    end
    issue_read(10'd7, 4'h7, v1, t1, d1, v0e, v0, t0, d0);
    checks++;
    if (d0 !== exp_wf || d1 !== exp_wf) begin
      failures++;
      $display("FAIL coll_after: d0=%h d1=%h expected %h", d0, d1, exp_wf);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] expv;
    expv = '0;
    expv[64 +: 64] = 64'hFFFF_FFFF_0000_0000;
    for (int i = 0; i < 16; i++) begin
      bus0.rd_en = 1'b1; bus0.rd_addr = 10'd7; bus0.rd_tag_in = 4'(i);
      tick();
      checks++;
      if (bus1.rd_valid !== 1'b1 || bus1.rd_tag !== 4'(i) || bus1.rd_data !== expv) begin
        failures++;
        $display("FAIL b2b_lat1 i=%0d: valid=%b tag=%h data=%h expected 1/%h/%h",
                 i, bus1.rd_valid, bus1.rd_tag, bus1.rd_data, 4'(i), expv);
      end
      if (i > 0) begin
        checks++;
        if (bus0.rd_valid !== 1'b1 || bus0.rd_tag !== 4'(i - 1)) begin
          failures++;
          $display("FAIL b2b_lat2 i=%0d: valid=%b tag=%h expected 1/%h", i, bus0.rd_valid, bus0.rd_tag, 4'(i - 1));
        end
      end
    end
    bus0.rd_en = 1'b0;
    tick();
    checks++;
    if (bus1.rd_valid !== 1'b0 || bus0.rd_valid !== 1'b1 || bus0.rd_tag !== 4'hF) begin
      failures++;
      $display("FAIL b2b_tail: v1=%b v0=%b tag0=%h expected 0/1/f", bus1.rd_valid, bus0.rd_valid, bus0.rd_tag);
    end
    tick();
    checks++;
    if (bus0.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: v0=%b expected 0", bus0.rd_valid);
    end
  endtask

  task automatic test_wr_err();
    logic v1, v0e, v0;
    logic [3:0] t1, t0;
    logic [255:0] d1, d0, expv;
    bus0.wr_en = 1'b1; bus0.wr_bank = 3'd4; bus0.wr_addr = 10'd5;
    bus0.wr_be = 8'hFF; bus0.wr_data = '1;
    tick();
    bus0.wr_en = 1'b0;
    checks++;
    if (bus0.wr_err !== 1'b1 || bus1.wr_err !== 1'b1) begin
      failures++;
      $display("FAIL wr_err_pulse: dut0=%b dut1=%b expected 1/1", bus0.wr_err, bus1.wr_err);
    end
    tick();
    checks++;
    if (bus0.wr_err !== 1'b0) begin
      failures++;
      $display("FAIL wr_err_clear: dut0=%b expected 0", bus0.wr_err);
    end
    expv = '0;
    expv[128 +: 64] = 64'h0000_0000_5566_7788;
    issue_read(10'd5, 4'h9, v1, t1, d1, v0e, v0, t0, d0);
    checks++;
    if (d0 !== expv || d1 !== expv) begin
      failures++;
      $display("FAIL wr_err_nochange: d0=%h d1=%h expected %h", d0, d1, expv);
    end
  endtask

  task automatic test_reset_mid_clear();
    int done_seen = 0;
    logic v1, v0e, v0;
    logic [3:0] t1, t0;
    logic [255:0] d1, d0, expv;
    do_write(3'd0, 10'd50,  8'hFF, 64'h0123_4567_89AB_CDEF);
    do_write(3'd3, 10'd300, 8'hFF, 64'hCAFE_F00D_DEAD_BEEF);
    bus0.clr_start = 1'b1;
    tick();
    bus0.clr_start = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus0.clr_busy !== 1'b0 || bus1.clr_busy !== 1'b0 || bus0.clr_done !== 1'b0) begin
      failures++;
      $display("FAIL midclr_reset: busy0=%b busy1=%b done0=%b expected 0/0/0", bus0.clr_busy, bus1.clr_busy, bus0.clr_done);
    end
    tick();
    rst_n = 1'b1;
    repeat (600) begin
      tick();
      if (bus0.clr_done || bus1.clr_done || bus0.clr_busy) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL midclr_nodone: done/busy cycles=%0d expected 0", done_seen);
    end
    issue_read(10'd50, 4'hA, v1, t1, d1, v0e, v0, t0, d0);
    checks++;
    if (v0 !== 1'b1 || d0 !== 256'h0 || d1 !== 256'h0) begin
      failures++;
      $display("FAIL midclr_addr50: v0=%b d0=%h d1=%h expected 1/0/0", v0, d0, d1);
    end
    expv = '0;
    expv[192 +: 64] = 64'hCAFE_F00D_DEAD_BEEF;
    issue_read(10'd300, 4'hB, v1, t1, d1, v0e, v0, t0, d0);
    checks++;
    if (v0 !== 1'b1 || t0 !== 4'hB || d0 !== expv || d1 !== expv) begin
      failures++;
      $display("FAIL midclr_addr300: v0=%b tag=%h d0=%h d1=%h expected 1/b/%h", v0, t0, d0, d1, expv);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_byte_write();
    test_collision();
    test_back_to_back();
    test_wr_err();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
